// File: rtl/lsu_axi_bridge_pkg.sv
// Shared definitions for the LSU-to-AXI bridge: FSM state encodings and AXI response codes.
package lsu_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/lsu_axi_bridge.sv
// Single-outstanding LSU request to single-beat AXI4 read/write bridge.
// Response is held on data_valid until the core accepts it with core_ready.
//
// state      | meaning
// IDLE       | waiting for re/we from the LSU
// RD_ADDR    | ar_valid high until ar_ready
// RD_DATA    | r_ready high until r_valid; capture data and error
// WR_REQ     | aw/w presented, each dropped after its own handshake
// WR_RESP    | b_ready high until b_valid; capture error
// RESP       | data_valid held until core_ready
module lsu_axi_bridge
    import lsu_axi_bridge_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [63:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  core_ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  data_valid,
    output logic                  err,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [AXI_ADDR_W-1:0] aw_addr,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_W-1:0]     w_data,
    output logic [DATA_W/8-1:0]   w_strb,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [1:0]            b_resp,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [AXI_ADDR_W-1:0] ar_addr,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_W-1:0]     r_data,
    input  logic [1:0]            r_resp
);

    state_t r_state;
    logic   r_aw_done;
    logic   r_w_done;

    logic w_aw_fin;
    logic w_w_fin;
    logic w_unused_addr;

    // A channel already done keeps its valid low, so its ready is don't-care.
    assign w_aw_fin      = r_aw_done | aw_ready;
    assign w_w_fin       = r_w_done  | w_ready;
    assign w_unused_addr = ^addr[63:AXI_ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            rdata      <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            aw_valid   <= 1'b0;
            aw_addr    <= '0;
            w_valid    <= 1'b0;
            w_data     <= '0;
            w_strb     <= '0;
            b_ready    <= 1'b0;
            ar_valid   <= 1'b0;
            ar_addr    <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (re) begin
                        ar_addr  <= addr[AXI_ADDR_W-1:0];
                        ar_valid <= 1'b1;
                        r_state  <= ST_RD_ADDR;
                    end else if (we && (wstrb != '0)) begin
                        aw_addr  <= addr[AXI_ADDR_W-1:0];
                        w_data   <= wdata;
                        w_strb   <= wstrb;
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        r_state  <= ST_WR_REQ;
                    end else if (we) begin
                        err        <= 1'b0;
                        data_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_valid) begin
                        rdata      <= r_data;
                        err        <= resp_is_err(r_resp);
                        r_ready    <= 1'b0;
                        data_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end
                end
                ST_WR_REQ: begin
                    if (w_aw_fin && w_w_fin) begin
                        aw_valid  <= 1'b0;
                        w_valid   <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        b_ready   <= 1'b1;
                        r_state   <= ST_WR_RESP;
                    end else begin
                        aw_valid  <= ~w_aw_fin;
                        w_valid   <= ~w_w_fin;
                        r_aw_done <= w_aw_fin;
                        r_w_done  <= w_w_fin;
                    end
                end
                ST_WR_RESP: begin
                    if (b_valid) begin
                        err        <= resp_is_err(b_resp);
                        b_ready    <= 1'b0;
                        data_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (core_ready) begin
                        data_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_axi_bridge.md
Name: lsu_axi_bridge

Overview:
- Memory-side responder for the load/store unit's simple data request interface.
- Accepts one read (re) or write (we) request at a time: address, 64-bit write data, 8-bit byte strobe.
- Converts each request into a single-beat AXI4 read or write transaction on the data master port.
- Returns read data plus a completion strobe that is held until the core accepts it. Sits between the LSU and the data-side AXI crossbar.

Parameters:
AXI_ADDR_W, 32, AXI address width; driven from the low AXI_ADDR_W bits of the 64-bit core address.
DATA_W, 64, core and AXI data width; the strobe width is DATA_W/8.

Ports:
clk  in  1  clock
rst  in  1  reset
re  in  1  read request from the LSU
we  in  1  write request from the LSU
addr  in  64  request address; reads arrive 8-byte aligned
wdata  in  64  write data, already lane-shifted
wstrb  in  8  write byte strobe (lane mask)
core_ready  in  1  core accepts the completed response this cycle
rdata  out  64  read data, held while data_valid=1
data_valid  out  1  response complete (read or write)
err  out  1  AXI error response; valid only with data_valid
aw_valid  out  1  AXI write-address valid
aw_ready  in  1  AXI write-address ready
aw_addr  out  AXI_ADDR_W  AXI write address
w_valid  out  1  AXI write-data valid
w_ready  in  1  AXI write-data ready
w_data  out  64  AXI write data
w_strb  out  8  AXI write strobe
b_valid  in  1  AXI write-response valid
b_ready  out  1  AXI write-response ready
b_resp  in  2  AXI write-response code
ar_valid  out  1  AXI read-address valid
ar_ready  in  1  AXI read-address ready
ar_addr  out  AXI_ADDR_W  AXI read address
r_valid  in  1  AXI read-data valid
r_ready  out  1  AXI read-data ready
r_data  in  64  AXI read data
r_resp  in  2  AXI read-response code

Behaviour:
- Reset and clocking: rst is synchronous and active-high; clk is the clock. On reset the FSM enters IDLE and every output is 0, including rdata and err. The fabric shares this rst.
- Fixed beat shape (tied off by the fabric, not ports): len=0, size=8 bytes, burst=INCR, id=0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - re=1: register addr; go to RD_ADDR.
  - we=1 with wstrb!=0: register addr, wdata and wstrb; go to WR_REQ.
  - we=1 with wstrb==0: go straight to RESP with err=0; no AXI traffic.
  - re and we both 1: read wins; the write is ignored.
- RD_ADDR: ar_valid=1, ar_addr is the registered address. ar_valid stays high and the address stays stable until ar_ready; then go to RD_DATA.
- RD_DATA: r_ready=1. On r_valid, register rdata=r_data and err=r_resp[1]; go to RESP.
- WR_REQ:
  - aw_valid and w_valid both assert in the first cycle.
  - Each drops independently after its own ready; aw_done and w_done flags track this.
  - Go to WR_RESP once both handshakes are done; both may finish in the same cycle.
  - w_ready arriving before aw_ready is legal.
- WR_RESP: b_ready=1. On b_valid, register err=b_resp[1] and leave rdata unchanged; go to RESP.
- RESP:
  - data_valid=1; rdata and err are held stable.
  - On core_ready, return to IDLE the next cycle; data_valid drops there.
  - The requester deasserts re/we or presents a new request in the cycle after core_ready. IDLE samples whatever is present, so no request is lost or duplicated.
- Minimum latency with zero-wait AXI (request seen in IDLE at cycle N):
  - read: ar_valid at N+1, r_ready at N+2, data_valid at N+3.
  - write: aw/w at N+1, b_ready at N+2, data_valid at N+3.
  - zero-strobe write: data_valid at N+1.
- Request inputs are ignored outside IDLE; the bridge holds at most one outstanding transaction.
- A response arriving with the wrong kind for the current state is ignored: b_valid in read states, r_valid in write states.
- Reset mid-transaction returns to IDLE at once and clears every output. Any in-flight beat is discarded.

Decomposition:
- Shared define file holds the state encodings (3-bit) and the AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- No sub-module: one FSM plus capture registers.

Test Plan:
- Read, zero wait: re=1, addr=0x8000_0008; fabric returns r_data=0x1122334455667788, OKAY -> ar_addr=0x80000008; data_valid at N+3; rdata=0x1122334455667788, err=0.
- Write with AW stalled: we=1, addr=0x8000_0010, wstrb=0x0C, wdata=0xABCD0000; w_ready=1 at once, aw_ready held low 3 cycles -> w_valid drops after 1 cycle; aw_valid stays high 4 cycles; b_ready only after both done; data_valid after b_valid.
- Zero strobe: we=1, wstrb=0x00 -> no aw/w/ar activity; data_valid=1 at N+1, err=0.
- Error plus back-pressure: read gets r_resp=DECERR, core_ready low 5 cycles -> data_valid and err=1 held 5 cycles with rdata stable; IDLE the cycle after core_ready.
- Reset in RD_DATA: assert rst while waiting for r_valid -> next cycle all outputs 0 and state IDLE; a new read after reset completes normally.
- Simultaneous re=we=1 -> only the AR channel toggles; aw_valid and w_valid stay 0.
